// File: rtl/mealyfsm_pkg.sv
// Constants shared by the 4-state Mealy encoder and its receive-side decoder.
// Both sides use this package so that the state encodings cannot drift apart.
package mealyfsm_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  // How to resolve z=1 received in S3, where x=0 and x=1 produce the same z.
  localparam logic AMB_STAY = 1'b0;
  localparam logic AMB_JUMP = 1'b1;

  typedef struct packed {
    state_t next_state;
    logic   x;
    logic   ambig;
    logic   illegal;
  } lut_out_t;

  function automatic logic policy_bit(input int amb_policy);
    return (amb_policy != 0) ? AMB_JUMP : AMB_STAY;
  endfunction

endpackage

// File: rtl/mealyfsm_decode_lut.sv
// Combinational inverse of the encoder mapping: given the tracked state and the
// received z, this block recovers x and the next state, and flags S3 symbols.
module mealyfsm_decode_lut
  import mealyfsm_pkg::*;
(
  input  state_t   state,
  input  logic     z,
  input  logic     policy,
  output lut_out_t lut_out
);

  always_comb begin
    lut_out.next_state = S0;
    lut_out.x          = 1'b0;
    lut_out.ambig      = 1'b0;
    lut_out.illegal    = 1'b0;
    case (state)
      S0: begin
        lut_out.x          = z;
        lut_out.next_state = z ? S1 : S0;
      end
      S1: begin
        lut_out.x          = ~z;
        lut_out.next_state = z ? S1 : S2;
      end
      S2: begin
        lut_out.x          = z;
        lut_out.next_state = z ? S3 : S2;
      end
      default: begin
        // In S3 the encoder emits z=1 for either x, so z=0 cannot occur.
        if (z) begin
          lut_out.ambig = 1'b1;
          if (policy == AMB_JUMP) begin
            lut_out.x          = 1'b1;
            lut_out.next_state = S1;
          end else begin
            lut_out.x          = 1'b0;
            lut_out.next_state = S3;
          end
        end else begin
          lut_out.illegal    = 1'b1;
          lut_out.next_state = S0;
        end
      end
    endcase
  end

endmodule

// File: rtl/mealyfsm_decoder.sv
// Receive-side decoder tracking the Mealy encoder state in lockstep.
// Registers the recovered x with one cycle of latency and counts ambiguous decodes.
//
// state | meaning
// S0    | idle / resync point; z mirrors x
// S1    | z=0 means x=1 (advance), z=1 means x=0 (hold)
// S2    | z mirrors x; x=1 advances to S3
// S3    | z=1 ambiguous (resolved by AMB_POLICY), z=0 illegal
module mealyfsm_decoder
  import mealyfsm_pkg::*;
#(
  parameter int AMB_POLICY = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             z_in,
  input  logic             z_valid,
  input  logic             sync_load,
  input  logic [1:0]       sync_state,
  output logic             x_out,
  output logic             x_valid,
  output logic             ambig,
  output logic             err,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] ambig_cnt
);

  localparam logic POLICY = policy_bit(AMB_POLICY);

  state_t           state_q, state_d;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             ambig_q, ambig_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lut_out_t         lut_out;

  mealyfsm_decode_lut u_lut (
    .state   (state_q),
    .z       (z_in),
    .policy  (POLICY),
    .lut_out (lut_out)
  );

  always_comb begin
    state_d   = state_q;
    x_out_d   = x_out_q;
    x_valid_d = 1'b0;
    ambig_d   = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    // A resync load wins over a same-cycle symbol, which is dropped.
    if (sync_load) begin
      state_d = sync_state;
    end else if (z_valid) begin
      if (lut_out.illegal) begin
        err_d   = 1'b1;
        state_d = S0;
      end else begin
        state_d   = lut_out.next_state;
        x_out_d   = lut_out.x;
        x_valid_d = 1'b1;
        ambig_d   = lut_out.ambig;
        if (lut_out.ambig && !(&cnt_q)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S0;
      x_out_q   <= 1'b0;
      x_valid_q <= 1'b0;
      ambig_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      ambig_q   <= ambig_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign x_out     = x_out_q;
  assign x_valid   = x_valid_q;
  assign ambig     = ambig_q;
  assign err       = err_q;
  assign state_out = state_q;
  assign ambig_cnt = cnt_q;

endmodule

// File: tb/tb_mealyfsm_decoder.sv
// Scoreboard bench for mealyfsm_decoder: two instances (stay/jump policy) share
// stimulus; the reference model inverts an encoder table by search.
module tb_mealyfsm_decoder;

  logic       clk = 1'b0;
  logic       rst, z_in, z_valid, sync_load;
  logic [1:0] sync_state;

  logic       xa, xva, amba, erra;
  logic [1:0] sta;
  logic [1:0] cnta;
  logic       xb, xvb, ambb, errb;
  logic [1:0] stb;
  logic [7:0] cntb;

  mealyfsm_decoder #(.AMB_POLICY(0), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .z_in(z_in), .z_valid(z_valid),
    .sync_load(sync_load), .sync_state(sync_state),
    .x_out(xa), .x_valid(xva), .ambig(amba), .err(erra),
    .state_out(sta), .ambig_cnt(cnta)
  );

  mealyfsm_decoder #(.AMB_POLICY(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .z_in(z_in), .z_valid(z_valid),
    .sync_load(sync_load), .sync_state(sync_state),
    .x_out(xb), .x_valid(xvb), .ambig(ambb), .err(errb),
    .state_out(stb), .ambig_cnt(cntb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x_out;
    int x_valid;
    int ambig;
    int err;
    int state;
    int cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int m_state[2];
  int m_x[2];
  int m_cnt[2];
  int cnt_max[2];
  int pol[2];

  int n_checks = 0;
  int n_fail   = 0;

  // Encoder as the team defines it: z and next state for each (state, x).
  function automatic int enc_z(int s, int x);
    case (s)
      0:       return x;
      1:       return (x != 0) ? 0 : 1;
      2:       return x;
      default: return 1;
    endcase
  endfunction

  function automatic int enc_ns(int s, int x);
    case (s)
      0:       return (x != 0) ? 1 : 0;
      1:       return (x != 0) ? 2 : 1;
      2:       return (x != 0) ? 3 : 2;
      default: return (x != 0) ? 1 : 3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Decoder model: find every x the encoder could have used to emit z.
  task automatic model(input int d, input bit r, input bit zv, input bit z,
                       input bit sl, input int ss, output exp_t e);
    int n;
    int c;
    e.x_valid = 0;
    e.ambig   = 0;
    e.err     = 0;
    if (r) begin
      m_state[d] = 0;
      m_x[d]     = 0;
      m_cnt[d]   = 0;
    end else if (sl) begin
      m_state[d] = ss;
    end else if (zv) begin
      n = 0;
      c = 0;
      for (int x = 0; x < 2; x++) begin
        if (enc_z(m_state[d], x) == int'(z)) begin
          n++;
          c = x;
        end
      end
      if (n == 0) begin
        e.err      = 1;
        m_state[d] = 0;
      end else begin
        if (n == 2) begin
          c       = pol[d];
          e.ambig = 1;
          if (m_cnt[d] < cnt_max[d]) m_cnt[d]++;
        end
        m_x[d]     = c;
        m_state[d] = enc_ns(m_state[d], c);
        e.x_valid  = 1;
      end
    end
    e.x_out = m_x[d];
    e.state = m_state[d];
    e.cnt   = m_cnt[d];
  endtask

  task automatic step(input bit r, input bit zv, input bit z, input bit sl, input int ss);
    exp_t e0, e1;
    rst        = r;
    z_valid    = zv;
    z_in       = z;
    sync_load  = sl;
    sync_state = 2'(ss);
    @(posedge clk);
    #1;
    model(0, r, zv, z, sl, ss, e0);
    q0.push_back(e0);
    model(1, r, zv, z, sl, ss, e1);
    q1.push_back(e1);
  endtask

  // Monitor: compares each registered response against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("a.x_valid", 32'(xva), e.x_valid);
        chk("a.x_out", 32'(xa), e.x_out);
        chk("a.ambig", 32'(amba), e.ambig);
        chk("a.err", 32'(erra), e.err);
        chk("a.state_out", 32'(sta), e.state);
        chk("a.ambig_cnt", 32'(cnta), e.cnt);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("b.x_valid", 32'(xvb), e.x_valid);
        chk("b.x_out", 32'(xb), e.x_out);
        chk("b.ambig", 32'(ambb), e.ambig);
        chk("b.err", 32'(errb), e.err);
        chk("b.state_out", 32'(stb), e.state);
        chk("b.ambig_cnt", 32'(cntb), e.cnt);
      end
    end
  end

  initial begin
    bit r, zv, z, sl;
    int ss;
    cnt_max[0] = 3;
    cnt_max[1] = 255;
    pol[0]     = 0;
    pol[1]     = 1;
    m_state[0] = 0; m_state[1] = 0;
    m_x[0] = 0;     m_x[1] = 0;
    m_cnt[0] = 0;   m_cnt[1] = 0;
    rst = 1'b1; z_in = 1'b0; z_valid = 1'b0; sync_load = 1'b0; sync_state = 2'b00;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Loopback z=1,0,1,1 (x=1,1,1,0 or 1,1,1,1 at the encoder).
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    @(negedge clk);
    chk("loop.a_state", 32'(sta), 3);
    chk("loop.b_state", 32'(stb), 1);
    chk("loop.a_x", 32'(xa), 0);
    chk("loop.b_x", 32'(xb), 1);
    chk("loop.a_cnt", 32'(cnta), 1);

    // Resync into S3, then an illegal z=0.
    step(0, 0, 0, 1, 3);
    step(0, 1, 0, 0, 0);
    @(negedge clk);
    chk("illegal.a_err", 32'(erra), 1);
    chk("illegal.a_state", 32'(sta), 0);

    // Gapped stream from S0.
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    @(negedge clk);
    chk("gap.a_state", 32'(sta), 2);

    // Load wins over a same-cycle symbol; then reset mid-stream.
    step(0, 1, 1, 1, 1);
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);

    // Counter saturation (2-bit on dut_a).
    step(0, 0, 0, 1, 3);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
    @(negedge clk);
    chk("sat.a_cnt", 32'(cnta), 3);
    chk("sat.a_state", 32'(sta), 3);

    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      sl = ($urandom_range(0, 19) == 0);
      zv = ($urandom_range(0, 3) != 0);
      z  = 1'($urandom_range(0, 1));
      ss = int'($urandom_range(0, 3));
      step(r, zv, z, sl, ss);
    end

    step(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q0.size() + q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
